pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 18 +
 rtl/ret_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the operation encodings driven onto pc_sequencer.op.
package pc_pkg;

  localparam int unsigned OpW = 3;

  typedef enum logic [OpW-1:0] {
    OpNext = 3'd0,
    OpBra  = 3'd1,
    OpBrc  = 3'd2,
    OpBrz  = 3'd3,
    OpJmp  = 3'd4,
    OpCall = 3'd5,
    OpRet  = 3'd6,
    OpHold = 3'd7
  } op_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack for pc_sequencer.
// Ports:
//   clk, reset   - clock and synchronous active-high reset (clears occupancy only)
//   push, pop    - push din / pop top entry; push ignored when full, pop ignored when empty
//   din          - address to push
//   dout         - current top-of-stack entry (undefined when empty)
//   full, empty  - occupancy status
//   count        - number of valid entries
module ret_stack #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  din,
  output logic [ADDR_W-1:0]                  dout,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   top_idx;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign top_idx = count_q - CntW'(1);
  assign dout    = mem_q[top_idx[PtrW-1:0]];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[count_q[PtrW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with relative/absolute branches and a return stack.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   en                - step strobe; all state holds while low
//   op                - operation (pc_pkg::op_e encoding)
//   offset            - ones'-complement signed relative offset
//   target            - absolute jump target
//   flag_c, flag_z    - branch condition flags, sampled with op
//   pc                - registered program counter
//   taken             - registered; high after a step that redirected away from pc+1
//   depth             - return-stack occupancy
//   overflow          - sticky: CALL attempted on a full stack
//   underflow         - sticky: RET attempted on an empty stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned OFFSET_W    = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [OpW-1:0]                   op,
  input  logic [OFFSET_W-1:0]              offset,
  input  logic [ADDR_W-1:0]                target,
  input  logic                             flag_c,
  input  logic                             flag_z,
  output logic [ADDR_W-1:0]                pc,
  output logic                             taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             overflow,
  output logic                             underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W-1:0] seq, rel, nxt;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_dout;
  logic              stk_full, stk_empty;

  assign seq = pc_q + ADDR_W'(1);
  // Adding the sign bit back converts ones'-complement offsets to two's complement.
  assign rel = pc_q + ADDR_W'($signed(offset)) + ADDR_W'(offset[OFFSET_W-1]);

  always_comb begin
    pc_d        = pc_q;
    taken_d     = taken_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push        = 1'b0;
    pop         = 1'b0;
    nxt         = seq;
    if (en) begin
      case (op_e'(op))
        OpNext: nxt = seq;
        OpBra:  nxt = rel;
        OpBrc:  nxt = flag_c ? rel : seq;
        OpBrz:  nxt = flag_z ? rel : seq;
        OpJmp:  nxt = target;
        OpCall: begin
          nxt = rel;
          if (stk_full) begin
            overflow_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        OpRet: begin
          if (stk_empty) begin
            nxt         = seq;
            underflow_d = 1'b1;
          end else begin
            nxt = stk_dout;
            pop = 1'b1;
          end
        end
        OpHold: nxt = pc_q;
        default: nxt = seq;
      endcase
      pc_d    = nxt;
      // Redirect is judged by value: a branch landing on pc+1 is not "taken".
      taken_d = (op_e'(op) != OpHold) && (nxt != seq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      taken_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      taken_q     <= taken_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push && !reset),
    .pop   (pop && !reset),
    .din   (seq),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty),
    .count (depth)
  );

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step pushes the reference model's expected
// state to a scoreboard queue, which is popped and compared one cycle later.
module tb_pc_sequencer;

  localparam int unsigned AW = 9;
  localparam int unsigned OW = 8;
  localparam int unsigned SD = 4;
  localparam int unsigned DW = $clog2(SD + 1);

  localparam logic [2:0] NEXT = 3'd0, BRA = 3'd1, BRC = 3'd2, BRZ = 3'd3;
  localparam logic [2:0] JMP = 3'd4, CALL = 3'd5, RET = 3'd6, HOLD = 3'd7;

  logic          clk = 1'b0;
  logic          reset, en, flag_c, flag_z;
  logic [2:0]    op;
  logic [OW-1:0] offset;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic          taken, overflow, underflow;
  logic [DW-1:0] depth;

  typedef struct {
    logic [AW-1:0] pc;
    logic          taken;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int m_pc    = 0;
  bit m_taken = 0;
  bit m_ovf   = 0;
  bit m_unf   = 0;
  int m_stack[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W      (AW),
    .OFFSET_W    (OW),
    .STACK_DEPTH (SD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .op        (op),
    .offset    (offset),
    .target    (target),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .pc        (pc),
    .taken     (taken),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: ones'-complement offset evaluated with integer arithmetic.
  task automatic model(input bit r, input bit e, input logic [2:0] o, input logic [OW-1:0] off,
                       input logic [AW-1:0] tgt, input bit fc, input bit fz);
    int seq, rel, offv, nx;
    if (r) begin
      m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
      m_stack.delete();
      return;
    end
    if (!e) return;
    seq  = (m_pc + 1) % (1 << AW);
    offv = off[OW-1] ? int'(off) - ((1 << OW) - 1) : int'(off);
    rel  = ((m_pc + offv) % (1 << AW) + (1 << AW)) % (1 << AW);
    case (o)
      BRA:  nx = rel;
      BRC:  nx = fc ? rel : seq;
      BRZ:  nx = fz ? rel : seq;
      JMP:  nx = int'(tgt);
      CALL: begin
        nx = rel;
        if (m_stack.size() == SD) m_ovf = 1;
        else m_stack.push_back(seq);
      end
      RET: begin
        if (m_stack.size() == 0) begin
          nx = seq;
          m_unf = 1;
        end else begin
          nx = m_stack.pop_back();
        end
      end
      HOLD:    nx = m_pc;
      default: nx = seq;
    endcase
    m_taken = (o != HOLD) && (nx != seq);
    m_pc    = nx;
  endtask

  task automatic step(input bit r, input bit e, input logic [2:0] o, input logic [OW-1:0] off,
                      input logic [AW-1:0] tgt, input bit fc, input bit fz, input string tag);
    exp_t x;
    exp_t g;
    @(negedge clk);
    reset = r; en = e; op = o; offset = off; target = tgt; flag_c = fc; flag_z = fz;
    model(r, e, o, off, tgt, fc, fz);
    x.pc = AW'(m_pc); x.taken = m_taken; x.depth = DW'(m_stack.size());
    x.ovf = m_ovf; x.unf = m_unf;
    sb.push_back(x);
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() != 0)
    else begin
      n_fails++;
      $error("FAIL %s: scoreboard empty, observed 0 entries expected 1", tag);
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk({tag, ".pc"}, 32'(pc), 32'(g.pc));
      chk({tag, ".taken"}, 32'(taken), 32'(g.taken));
      chk({tag, ".depth"}, 32'(depth), 32'(g.depth));
      chk({tag, ".ovf"}, 32'(overflow), 32'(g.ovf));
      chk({tag, ".unf"}, 32'(underflow), 32'(g.unf));
    end
  endtask

  task automatic jmp(input logic [AW-1:0] t);
    step(0, 1, JMP, 8'h00, t, 0, 0, "jmp");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; en = 1; op = CALL; offset = 0; target = 0; flag_c = 0; flag_z = 0;
    step(1, 1, CALL, 8'h05, 9'h000, 0, 0, "reset0");
    step(1, 0, RET, 8'h00, 9'h000, 0, 0, "reset1");
    chk("reset.pc", 32'(pc), 32'h0);

    // Sequential stepping
    step(0, 1, NEXT, 8'h00, 9'h000, 0, 0, "next1");
    step(0, 1, NEXT, 8'h00, 9'h000, 0, 0, "next2");
    step(0, 1, NEXT, 8'h00, 9'h000, 0, 0, "next3");
    chk("next.pc3", 32'(pc), 32'h3);
    chk("next.taken", 32'(taken), 32'h0);

    // Relative branches, ones'-complement offsets
    jmp(9'h010);
    step(0, 1, BRA, 8'h05, 9'h000, 0, 0, "bra_p5");
    chk("bra_p5.const", 32'(pc), 32'h015);
    jmp(9'h010);
    step(0, 1, BRA, 8'hFE, 9'h000, 0, 0, "bra_m1");
    chk("bra_m1.const", 32'(pc), 32'h00F);
    jmp(9'h010);
    step(0, 1, BRA, 8'hFF, 9'h000, 0, 0, "bra_m0");
    chk("bra_m0.const", 32'(pc), 32'h010);
    chk("bra_m0.taken", 32'(taken), 32'h1);
    step(0, 1, BRA, 8'h01, 9'h000, 0, 0, "bra_seq");
    chk("bra_seq.taken", 32'(taken), 32'h0);

    // Wraparound
    jmp(9'h1FF);
    step(0, 1, NEXT, 8'h00, 9'h000, 0, 0, "wrap_next");
    chk("wrap_next.const", 32'(pc), 32'h000);
    jmp(9'h1FE);
    step(0, 1, BRA, 8'h03, 9'h000, 0, 0, "wrap_bra");
    chk("wrap_bra.const", 32'(pc), 32'h001);

    // Conditional branches
    jmp(9'h020);
    step(0, 1, BRZ, 8'h10, 9'h000, 1, 0, "brz_nt");
    chk("brz_nt.const", 32'(pc), 32'h021);
    jmp(9'h020);
    step(0, 1, BRZ, 8'h10, 9'h000, 0, 1, "brz_t");
    chk("brz_t.const", 32'(pc), 32'h030);
    jmp(9'h020);
    step(0, 1, BRC, 8'h10, 9'h000, 0, 1, "brc_nt");
    chk("brc_nt.const", 32'(pc), 32'h021);
    jmp(9'h020);
    step(0, 1, BRC, 8'h10, 9'h000, 1, 0, "brc_t");
    chk("brc_t.const", 32'(pc), 32'h030);

    // en=0 holds everything, HOLD keeps pc and clears taken
    step(0, 0, JMP, 8'h00, 9'h0AA, 0, 0, "en0_jmp");
    step(0, 0, CALL, 8'h10, 9'h000, 0, 0, "en0_call");
    step(0, 1, HOLD, 8'h00, 9'h000, 0, 0, "hold");

    // Nested calls through overflow, then returns through underflow
    jmp(9'h100);
    for (int i = 0; i < 5; i++) step(0, 1, CALL, 8'h10, 9'h000, 0, 0, "call");
    chk("call.depth_full", 32'(depth), 32'h4);
    chk("call.ovf", 32'(overflow), 32'h1);
    step(0, 1, RET, 8'h00, 9'h000, 0, 0, "ret1");
    chk("ret1.const", 32'(pc), 32'h131);
    step(0, 1, RET, 8'h00, 9'h000, 0, 0, "ret2");
    step(0, 1, RET, 8'h00, 9'h000, 0, 0, "ret3");
    step(0, 1, RET, 8'h00, 9'h000, 0, 0, "ret4");
    chk("ret4.const", 32'(pc), 32'h101);
    step(0, 1, RET, 8'h00, 9'h000, 0, 0, "ret5");
    chk("ret5.const", 32'(pc), 32'h102);
    chk("ret5.unf", 32'(underflow), 32'h1);

    // Reset beats a simultaneous CALL
    step(1, 1, NEXT, 8'h00, 9'h000, 0, 0, "rst2");
    jmp(9'h050);
    step(1, 1, CALL, 8'h10, 9'h000, 0, 0, "rst_call");
    step(0, 1, RET, 8'h00, 9'h000, 0, 0, "rst_ret");
    chk("rst_ret.const", 32'(pc), 32'h001);
    chk("rst_ret.unf", 32'(underflow), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
